// File: rtl/shifter_r_arb_if.sv
// shifter_r_arb_if
//   Bundles the requester, shifter and result-consumer signals of
//   shifter_r_arb.
//   slave  : the arbiter side (takes requests and sh_out, drives grants,
//            shifter operands, the result and the debug state).
//   master : the environment side (requesters, shifter, consumer).
//
//   Handshake: a result transfers on a rising clk edge where res_vld and
//   res_rdy are both 1. res_vld, res_id, res_data and res_err stay stable
//   while res_vld=1 and res_rdy=0. res_vld never depends combinationally on
//   res_rdy.
//   Request side: a requester holds req, its operand and its shift amount
//   until it sees its gnt bit. The grant bit is high for exactly one cycle.
interface shifter_r_arb_if #(
    parameter int bit_addr_shi = 19,
    parameter int bit_chip     = 6,
    parameter int bit_shi_r    = 5,
    parameter int n_req        = 4,
    parameter int bit_req      = 2
);
    logic [n_req-1:0]                         req;
    logic [n_req*(bit_addr_shi+bit_chip)-1:0] req_in;
    logic [n_req*bit_shi_r-1:0]               req_sb_r;
    logic [n_req-1:0]                         gnt;
    logic [bit_addr_shi+bit_chip-1:0]         sh_in;
    logic [bit_shi_r-1:0]                     sh_sb_r;
    logic [bit_chip-1:0]                      sh_out;
    logic                                     res_vld;
    logic                                     res_rdy;
    logic [bit_req-1:0]                       res_id;
    logic [bit_chip-1:0]                      res_data;
    logic                                     res_err;
    logic [1:0]                               state_dbg;

    modport slave (
        input  req, req_in, req_sb_r, sh_out, res_rdy,
        output gnt, sh_in, sh_sb_r, res_vld, res_id, res_data, res_err, state_dbg
    );

    modport master (
        output req, req_in, req_sb_r, sh_out, res_rdy,
        input  gnt, sh_in, sh_sb_r, res_vld, res_id, res_data, res_err, state_dbg
    );
endinterface

// File: rtl/shifter_r_arb.sv
// shifter_r_arb
//   Round-robin arbiter and sequencer sharing one registered rounding right
//   shifter between n_req requesters. A granted operand and shift amount are
//   latched onto sh_in/sh_sb_r (ISSUE), the shifter result is captured one
//   cycle later (CAPT) and presented with the owner id until accepted (HOLD).
//   Illegal shift amounts never reach the shifter; they complete with
//   res_err=1 and res_data=0.
// Ports:
//   clk  : rising-edge clock
//   clr  : synchronous active-high reset
//   bus  : shifter_r_arb_if.slave (requests, grants, shifter link, result,
//          state_dbg = current FSM state: 0 IDLE, 1 ISSUE, 2 CAPT, 3 HOLD)
module shifter_r_arb #(
    parameter int bit_addr_shi = 19,
    parameter int bit_chip     = 6,
    parameter int bit_shi_r    = 5,
    parameter int sb_r_min     = 3,
    parameter int n_req        = 4,
    parameter int bit_req      = 2
) (
    input  logic           clk,
    input  logic           clr,
    shifter_r_arb_if.slave bus
);
    localparam int op_w = bit_addr_shi + bit_chip;
    localparam logic [bit_shi_r-1:0] sb_lo = bit_shi_r'(sb_r_min);
    localparam logic [bit_shi_r-1:0] sb_hi = bit_shi_r'(bit_addr_shi - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [bit_req-1:0]   last_q;
    logic [bit_req-1:0]   win;
    logic                 any_req;
    logic                 take;
    logic                 win_ill;
    logic                 err_q;
    logic [op_w-1:0]      ops [n_req];
    logic [bit_shi_r-1:0] sbs [n_req];

    logic [n_req-1:0]     gnt_q;
    logic [op_w-1:0]      sh_in_q;
    logic [bit_shi_r-1:0] sh_sb_r_q;
    logic                 res_vld_q;
    logic [bit_req-1:0]   res_id_q;
    logic [bit_chip-1:0]  res_data_q;
    logic                 res_err_q;

    // Unpack the per-requester slices.
    always_comb begin
        for (int k = 0; k < n_req; k++) begin
            ops[k] = bus.req_in[k*op_w +: op_w];
            sbs[k] = bus.req_sb_r[k*bit_shi_r +: bit_shi_r];
        end
    end

    assign any_req = |bus.req;

    // Search starts one past the last grantee and wraps, so the most recent
    // winner has the lowest priority.
    always_comb begin
        int   idx;
        logic found;
        win   = last_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= n_req; i++) begin
            idx = (int'(last_q) + i) % n_req;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = bit_req'(idx);
            end
        end
    end

    assign win_ill = (sbs[win] < sb_lo) || (sbs[win] > sb_hi);

    // Next-state; take marks the edges where arbitration and latching occur.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CAPT;
            CAPT:  state_d = HOLD;
            HOLD: begin
                if (bus.res_rdy) begin
                    if (any_req) begin
                        take    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            last_q     <= bit_req'(n_req - 1);
            gnt_q      <= '0;
            sh_in_q    <= '0;
            sh_sb_r_q  <= '0;
            err_q      <= 1'b0;
            res_vld_q  <= 1'b0;
            res_id_q   <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            gnt_q <= take ? ({{(n_req-1){1'b0}}, 1'b1} << win) : '0;
            if (take) begin
                sh_in_q   <= ops[win];
                // An illegal amount is replaced by 0 so the shifter only
                // ever sees a supported value; the result is overridden.
                sh_sb_r_q <= win_ill ? '0 : sbs[win];
                err_q     <= win_ill;
                res_id_q  <= win;
                last_q    <= win;
            end
            if (state_q == CAPT) begin
                res_data_q <= err_q ? '0 : bus.sh_out;
                res_err_q  <= err_q;
                res_vld_q  <= 1'b1;
            end else if (state_q == HOLD && bus.res_rdy) begin
                res_vld_q <= 1'b0;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sh_in     = sh_in_q;
    assign bus.sh_sb_r   = sh_sb_r_q;
    assign bus.res_vld   = res_vld_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_shifter_r_arb.sv
// tb_shifter_r_arb
//   Bench for shifter_r_arb. Contains a registered rounding right-shifter
//   model feeding sh_out, directed requester stimulus, and a result monitor
//   comparing {res_id, res_err, res_data} against an expected queue.
module tb_shifter_r_arb;
    localparam int bit_addr_shi = 19;
    localparam int bit_chip     = 6;
    localparam int bit_shi_r    = 5;
    localparam int sb_r_min     = 3;
    localparam int n_req        = 4;
    localparam int bit_req      = 2;
    localparam int op_w         = bit_addr_shi + bit_chip;
    localparam int exp_w        = bit_req + 1 + bit_chip;

    logic clk;
    logic clr;

    int checks   = 0;
    int failures = 0;
    logic [exp_w-1:0] exp_q[$];

    shifter_r_arb_if #(
        .bit_addr_shi(bit_addr_shi), .bit_chip(bit_chip), .bit_shi_r(bit_shi_r),
        .n_req(n_req), .bit_req(bit_req)
    ) bus ();

    shifter_r_arb #(
        .bit_addr_shi(bit_addr_shi), .bit_chip(bit_chip), .bit_shi_r(bit_shi_r),
        .sb_r_min(sb_r_min), .n_req(n_req), .bit_req(bit_req)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shifter model ----------------
    function automatic logic [bit_chip-1:0] shift_round(input logic [op_w-1:0] v,
                                                        input logic [bit_shi_r-1:0] sb);
        logic [op_w-1:0] t;
        logic            rb;
        t  = v >> sb;
        rb = (sb == 0) ? 1'b0 : v[sb - 1];
        return t[bit_chip-1:0] + {{(bit_chip-1){1'b0}}, rb};
    endfunction

    always_ff @(posedge clk) begin
        if (clr) bus.sh_out <= '0;
        else     bus.sh_out <= shift_round(bus.sh_in, bus.sh_sb_r);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int id, input logic [op_w-1:0] op, input logic [bit_shi_r-1:0] sb);
        bus.req_in[id*op_w +: op_w]             = op;
        bus.req_sb_r[id*bit_shi_r +: bit_shi_r] = sb;
        bus.req[id]                             = 1'b1;
    endtask

    task automatic push_exp(input int id, input logic err, input logic [bit_chip-1:0] d);
        logic [bit_req-1:0] idv;
        idv = bit_req'(id);
        exp_q.push_back({idv, err, d});
    endtask

    // One isolated operation from IDLE with res_rdy=1; called in cycle 0.
    task automatic single_op(input string name, input int id, input logic [op_w-1:0] op,
                             input logic [bit_shi_r-1:0] sb, input logic [bit_chip-1:0] d,
                             input logic err, input logic [bit_shi_r-1:0] sh_sb_exp);
        logic [n_req-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        set_req(id, op, sb);
        push_exp(id, err, d);
        tick();  // cycle 1: ISSUE
        check({name, "_gnt"}, 32'(bus.gnt), 32'(oh));
        check({name, "_sh_sb_r"}, 32'(bus.sh_sb_r), 32'(sh_sb_exp));
        bus.req[id] = 1'b0;
        tick();  // cycle 2: CAPT
        check({name, "_vld_c2"}, 32'(bus.res_vld), 32'd0);
        tick();  // cycle 3: HOLD
        check({name, "_vld_c3"}, 32'(bus.res_vld), 32'd1);
        tick();  // cycle 4: back in IDLE
        check({name, "_vld_c4"}, 32'(bus.res_vld), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [exp_w-1:0] got;
        logic [exp_w-1:0] exp;
        if (!clr && bus.res_vld && bus.res_rdy) begin
            got = {bus.res_id, bus.res_err, bus.res_data};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL result_unexpected: got 0x%0h expected none at %0t", got, $time);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL result: got id=%0d err=%0d data=%0d expected id=%0d err=%0d data=%0d at %0t",
                             got[exp_w-1 -: bit_req], got[bit_chip], got[bit_chip-1:0],
                             exp[exp_w-1 -: bit_req], exp[bit_chip], exp[bit_chip-1:0], $time);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [n_req-1:0] g_exp;
        int               waited;
        clr          = 1'b1;
        bus.req      = '0;
        bus.req_in   = '0;
        bus.req_sb_r = '0;
        bus.res_rdy  = 1'b1;
        tick();
        tick();
        // Reset state
        check("rst_gnt",      32'(bus.gnt),       32'd0);
        check("rst_sh_in",    32'(bus.sh_in),     32'd0);
        check("rst_sh_sb_r",  32'(bus.sh_sb_r),   32'd0);
        check("rst_res_vld",  32'(bus.res_vld),   32'd0);
        check("rst_res_id",   32'(bus.res_id),    32'd0);
        check("rst_res_data", 32'(bus.res_data),  32'd0);
        check("rst_res_err",  32'(bus.res_err),   32'd0);
        check("rst_state",    32'(bus.state_dbg), 32'd0);
        clr = 1'b0;

        // Legal, rounding wrap, maximum shift, illegal low/high
        single_op("legal44",   0, 25'd44,     5'd3,  6'd6,  1'b0, 5'd3);
        single_op("wrap508",   1, 25'd508,    5'd3,  6'd0,  1'b0, 5'd3);
        single_op("max18",     2, 25'd262144, 5'd18, 6'd1,  1'b0, 5'd18);
        single_op("legal1000", 3, 25'd1000,   5'd4,  6'd63, 1'b0, 5'd4);
        single_op("ill2",      3, 25'd44,     5'd2,  6'd0,  1'b1, 5'd0);
        single_op("ill19",     0, 25'd12345,  5'd19, 6'd0,  1'b1, 5'd0);

        // Round-robin with all four requesting continuously from reset.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_req(0, 25'd44,  5'd3);
        set_req(1, 25'd508, 5'd3);
        set_req(2, 25'd16,  5'd3);
        set_req(3, 25'd20,  5'd3);
        push_exp(0, 1'b0, 6'd6);
        push_exp(1, 1'b0, 6'd0);
        push_exp(2, 1'b0, 6'd2);
        push_exp(3, 1'b0, 6'd3);
        push_exp(0, 1'b0, 6'd6);
        for (int c = 1; c <= 13; c++) begin
            tick();
            g_exp = '0;
            if (c % 3 == 1) g_exp[((c - 1) / 3) % n_req] = 1'b1;
            check($sformatf("rr_gnt_c%0d", c), 32'(bus.gnt), 32'(g_exp));
            check($sformatf("rr_excl_c%0d", c), 32'((|bus.gnt) && bus.res_vld), 32'd0);
            if (c == 13) bus.req = '0;
        end
        repeat (3) tick();
        check("rr_idle", 32'(bus.state_dbg), 32'd0);

        // Back-pressure: five HOLD cycles with res_rdy low, req1 pending.
        bus.res_rdy = 1'b0;
        set_req(0, 25'd44, 5'd3);
        push_exp(0, 1'b0, 6'd6);
        push_exp(1, 1'b0, 6'd3);
        tick();  // cycle 1
        bus.req[0] = 1'b0;
        tick();  // cycle 2
        tick();  // cycle 3
        set_req(1, 25'd20, 5'd3);
        for (int c = 3; c <= 7; c++) begin
            if (c > 3) tick();
            check($sformatf("bp_vld_c%0d", c),  32'(bus.res_vld),  32'd1);
            check($sformatf("bp_data_c%0d", c), 32'(bus.res_data), 32'd6);
            check($sformatf("bp_id_c%0d", c),   32'(bus.res_id),   32'd0);
            check($sformatf("bp_gnt_c%0d", c),  32'(bus.gnt),      32'd0);
        end
        bus.res_rdy = 1'b1;
        tick();  // cycle 8: req1 granted on the accepting edge
        check("bp_gnt_req1", 32'(bus.gnt),     32'b0010);
        check("bp_vld_drop", 32'(bus.res_vld), 32'd0);
        bus.req[1] = 1'b0;
        repeat (3) tick();

        // Reset during CAPT discards the operation and the pointer.
        set_req(0, 25'd44, 5'd3);
        tick();  // cycle 1: ISSUE
        bus.req[0] = 1'b0;
        tick();  // cycle 2: CAPT
        check("clr_in_capt", 32'(bus.state_dbg), 32'd2);
        clr = 1'b1;
        tick();  // cycle 3
        check("clr_state",    32'(bus.state_dbg), 32'd0);
        check("clr_vld",      32'(bus.res_vld),   32'd0);
        check("clr_gnt",      32'(bus.gnt),       32'd0);
        check("clr_sh_in",    32'(bus.sh_in),     32'd0);
        check("clr_sh_sb_r",  32'(bus.sh_sb_r),   32'd0);
        check("clr_res_data", 32'(bus.res_data),  32'd0);
        check("clr_res_id",   32'(bus.res_id),    32'd0);
        check("clr_res_err",  32'(bus.res_err),   32'd0);
        clr = 1'b0;
        set_req(0, 25'd508, 5'd3);
        set_req(3, 25'd16,  5'd3);
        push_exp(0, 1'b0, 6'd0);
        push_exp(3, 1'b0, 6'd2);
        tick();  // cycle 4
        check("post_clr_gnt0", 32'(bus.gnt), 32'b0001);
        bus.req[0] = 1'b0;
        tick();
        tick();
        tick();  // cycle 7: accepting HOLD edge grants req3
        check("post_clr_gnt3", 32'(bus.gnt), 32'b1000);
        bus.req[3] = 1'b0;

        // Drain with a bounded wait.
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            tick();
            waited++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
